// File: rtl/mul_sel_pkg.sv
// mul_sel_pkg: phase encoding, sequencer state and shift-add product for mul_sel_sched
package mul_sel_pkg;
    localparam int PW = 35;
    localparam logic [1:0] PH_X1 = 2'd0;
    localparam logic [1:0] PH_X3 = 2'd1;
    localparam logic [1:0] PH_X7 = 2'd2;
    localparam logic [1:0] PH_X8 = 2'd3;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic logic [PW-1:0] mul_product(input logic [PW-1:0] d, input logic [1:0] ph);
        return ph == PH_X1 ? d :
               ph == PH_X3 ? (d << 1) + d :
               ph == PH_X7 ? (d << 3) - d : d << 3;
    endfunction
endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter, search starts at ptr and wraps; first valid wins
module rr_arb #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win
);
    always_comb begin
        gnt = '0;
        win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (en && req[(int'(ptr) + k) % N]) begin
                gnt = N'(1) << ((int'(ptr) + k) % N);
                win = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/mul_sel_sched.sv
// mul_sel_sched: round-robin scheduler and 4-phase sequencer for the x1/x3/x7/x8 datapath
// MULSEL_OUT_REG_EN adds one output register stage (accept-to-phase-0 latency 2)
module mul_sel_sched
    import mul_sel_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW = 8,
    localparam int OW = DW + 3,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                out_valid,
    output logic                out_first,
    output logic [1:0]          out_phase,
    output logic [IDW-1:0]      out_id,
    output logic [OW-1:0]       out_data,
    output logic                busy
);
    state_t state;
    logic [1:0] phase;
    logic [DW-1:0] op;
    logic [IDW-1:0] id, ptr, win;
    logic [N_REQ-1:0] gnt;
    logic arb_en, accept;
    logic s_valid, s_first;
    logic [1:0] s_phase;
    logic [IDW-1:0] s_id;
    logic [OW-1:0] s_data;
    // phase stays 0 in IDLE, so phase==PH_X8 only occurs in RUN
    assign arb_en = !rst && (state == IDLE || phase == PH_X8);
    rr_arb #(.N(N_REQ), .IW(IDW)) u_arb (
        .req(req_valid),
        .en (arb_en),
        .ptr(ptr),
        .gnt(gnt),
        .win(win)
    );
    assign req_ready = gnt;
    assign accept = |gnt;
    assign busy = state == RUN;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= PH_X1;
            op <= '0;
            id <= '0;
            ptr <= '0;
        end else if (accept) begin
            state <= RUN;
            phase <= PH_X1;
            op <= req_data[win*DW +: DW];
            id <= win;
            ptr <= win == IDW'(N_REQ - 1) ? '0 : win + 1'b1;
        end else if (state == RUN) begin
            state <= phase == PH_X8 ? IDLE : RUN;
            phase <= phase == PH_X8 ? PH_X1 : phase + 2'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_first <= 1'b0;
            s_phase <= '0;
            s_id <= '0;
            s_data <= '0;
        end else begin
            s_valid <= state == RUN;
            s_first <= state == RUN && phase == PH_X1;
            s_phase <= phase;
            s_id <= id;
            s_data <= OW'(mul_product(PW'(op), phase));
        end
    end
`ifdef MULSEL_OUT_REG_EN
    logic q_valid, q_first;
    logic [1:0] q_phase;
    logic [IDW-1:0] q_id;
    logic [OW-1:0] q_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_first <= 1'b0;
            q_phase <= '0;
            q_id <= '0;
            q_data <= '0;
        end else begin
            q_valid <= s_valid;
            q_first <= s_first;
            q_phase <= s_phase;
            q_id <= s_id;
            q_data <= s_data;
        end
    end
    assign out_valid = q_valid;
    assign out_first = q_first;
    assign out_phase = q_phase;
    assign out_id = q_id;
    assign out_data = q_data;
`else
    assign out_valid = s_valid;
    assign out_first = s_first;
    assign out_phase = s_phase;
    assign out_id = s_id;
    assign out_data = s_data;
`endif
endmodule

// File: tb/tb_mul_sel_sched.sv
// tb_mul_sel_sched: directed scenarios for the mul_sel_sched scheduler/sequencer
module tb_mul_sel_sched;
    localparam int N = 4;
    localparam int DW = 8;
    localparam int OW = 11;
    localparam int IDW = 2;
`ifdef MULSEL_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic out_valid, out_first, busy;
    logic [1:0] out_phase;
    logic [IDW-1:0] out_id;
    logic [OW-1:0] out_data;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul_sel_sched #(.N_REQ(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_first(out_first),
        .out_phase(out_phase), .out_id(out_id), .out_data(out_data), .busy(busy)
    );

    function automatic logic [OW-1:0] exp_prod(input logic [7:0] d, input int ph);
        int m;
        m = ph == 0 ? 1 : ph == 1 ? 3 : ph == 2 ? 7 : 8;
        return OW'(int'(d) * m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b0001;
        req_data[7:0] = 8'hFF;
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        vectors++; if (out_first !== 1'b0) begin miscompares++; $display("FAIL reset out_first got %b exp 0", out_first); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset out_data got %0d exp 0", out_data); end
        vectors++; if (out_id !== '0) begin miscompares++; $display("FAIL reset out_id got %0d exp 0", out_id); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b exp 0", busy); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset req_ready got %b exp 0000", req_ready); end
    endtask

    task automatic test_single();
        logic [OW-1:0] tbl [4];
        int p;
        logic ev;
        tbl[0] = 11'd255; tbl[1] = 11'd765; tbl[2] = 11'd1785; tbl[3] = 11'd2040;
        rst = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL single idle ready got %b exp 0001", req_ready); end
        for (int n = 1; n <= 5 + LAT; n++) begin
            tick();
            if (n == 1) req_valid = '0;
            #1;
            ev = n >= 1 + LAT && n <= 4 + LAT;
            p = n - 1 - LAT;
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL single out_valid n=%0d got %b exp %b", n, out_valid, ev); end
            vectors++; if (busy !== (n <= 4)) begin miscompares++; $display("FAIL single busy n=%0d got %b exp %b", n, busy, n <= 4); end
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL single ready n=%0d got %b exp 0000", n, req_ready); end
            if (ev) begin
                vectors++; if (out_phase !== 2'(p)) begin miscompares++; $display("FAIL single phase n=%0d got %0d exp %0d", n, out_phase, p); end
                vectors++; if (out_data !== tbl[p]) begin miscompares++; $display("FAIL single data n=%0d got %0d exp %0d", n, out_data, tbl[p]); end
                vectors++; if (out_first !== (p == 0)) begin miscompares++; $display("FAIL single first n=%0d got %b exp %b", n, out_first, p == 0); end
                vectors++; if (out_id !== 2'd0) begin miscompares++; $display("FAIL single id n=%0d got %0d exp 0", n, out_id); end
            end
        end
    endtask

    task automatic test_all_rr();
        logic [7:0] dat [4];
        logic [N-1:0] er;
        int p, k, id;
        logic ev;
        dat[0] = 8'd10; dat[1] = 8'd200; dat[2] = 8'd77; dat[3] = 8'd255;
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
        req_valid = '1;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rr idle ready got %b exp 0001", req_ready); end
        for (int n = 1; n <= 21; n++) begin
            tick();
            er = (n % 4 == 0) ? 4'(1 << ((n / 4) % 4)) : 4'b0000;
            ev = n >= 1 + LAT;
            p = (n - 1 - LAT) % 4;
            k = (n - 1 - LAT) / 4;
            id = k % 4;
            vectors++; if (req_ready !== er) begin miscompares++; $display("FAIL rr ready n=%0d got %b exp %b", n, req_ready, er); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rr busy n=%0d got %b exp 1", n, busy); end
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL rr out_valid n=%0d got %b exp %b", n, out_valid, ev); end
            if (ev) begin
                vectors++; if (out_phase !== 2'(p)) begin miscompares++; $display("FAIL rr phase n=%0d got %0d exp %0d", n, out_phase, p); end
                vectors++; if (out_id !== 2'(id)) begin miscompares++; $display("FAIL rr id n=%0d got %0d exp %0d", n, out_id, id); end
                vectors++; if (out_data !== exp_prod(dat[id], p)) begin miscompares++; $display("FAIL rr data n=%0d got %0d exp %0d", n, out_data, exp_prod(dat[id], p)); end
                vectors++; if (out_first !== (p == 0)) begin miscompares++; $display("FAIL rr first n=%0d got %b exp %b", n, out_first, p == 0); end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int p;
        logic ev;
        logic [N-1:0] er;
        do_reset();
        req_data[2*DW +: DW] = 8'd10;
        req_valid = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL b2b idle ready got %b exp 0100", req_ready); end
        for (int n = 1; n <= 13; n++) begin
            tick();
            er = (n % 4 == 0) ? 4'b0100 : 4'b0000;
            ev = n >= 1 + LAT;
            p = (n - 1 - LAT) % 4;
            vectors++; if (req_ready !== er) begin miscompares++; $display("FAIL b2b ready n=%0d got %b exp %b", n, req_ready, er); end
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL b2b out_valid n=%0d got %b exp %b", n, out_valid, ev); end
            if (ev) begin
                vectors++; if (out_data !== exp_prod(8'd10, p)) begin miscompares++; $display("FAIL b2b data n=%0d got %0d exp %0d", n, out_data, exp_prod(8'd10, p)); end
                vectors++; if (out_id !== 2'd2) begin miscompares++; $display("FAIL b2b id n=%0d got %0d exp 2", n, out_id); end
                vectors++; if (out_phase !== 2'(p)) begin miscompares++; $display("FAIL b2b phase n=%0d got %0d exp %0d", n, out_phase, p); end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data[7:0] = 8'd5;
        req_valid = 4'b0001;
        for (int n = 1; n <= 2 + LAT; n++) begin
            tick();
            if (n == 1) req_valid = '0;
        end
        vectors++; if (out_valid !== 1'b1 || out_phase !== 2'd1) begin miscompares++; $display("FAIL mid pre-reset valid/phase got %b/%0d exp 1/1", out_valid, out_phase); end
        vectors++; if (out_data !== 11'd15) begin miscompares++; $display("FAIL mid pre-reset data got %0d exp 15", out_data); end
        rst = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid out_valid got %b exp 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid busy got %b exp 0", busy); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid ready in rst got %b exp 0000", req_ready); end
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid aftermath n=%0d valid/busy got %b/%b exp 0/0", n, out_valid, busy); end
        end
        req_valid = 4'b0011;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid ptr ready got %b exp 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_mid_request();
        int p, k;
        logic ev;
        logic [N-1:0] er;
        logic [7:0] d;
        logic [IDW-1:0] eid;
        do_reset();
        req_data[1*DW +: DW] = 8'd7;
        req_data[3*DW +: DW] = 8'd9;
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL midreq idle ready got %b exp 0010", req_ready); end
        for (int n = 1; n <= 9 + LAT; n++) begin
            tick();
            if (n == 1) req_valid = '0;
            if (n == 2) req_valid = 4'b1000;
            if (n == 5) req_valid = '0;
            #1;
            er = (n == 4) ? 4'b1000 : 4'b0000;
            ev = n >= 1 + LAT && n <= 8 + LAT;
            p = (n - 1 - LAT) % 4;
            k = (n - 1 - LAT) / 4;
            d = k == 0 ? 8'd7 : 8'd9;
            eid = k == 0 ? 2'd1 : 2'd3;
            vectors++; if (req_ready !== er) begin miscompares++; $display("FAIL midreq ready n=%0d got %b exp %b", n, req_ready, er); end
            vectors++; if (busy !== (n <= 8)) begin miscompares++; $display("FAIL midreq busy n=%0d got %b exp %b", n, busy, n <= 8); end
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL midreq out_valid n=%0d got %b exp %b", n, out_valid, ev); end
            if (ev) begin
                vectors++; if (out_id !== eid) begin miscompares++; $display("FAIL midreq id n=%0d got %0d exp %0d", n, out_id, eid); end
                vectors++; if (out_data !== exp_prod(d, p)) begin miscompares++; $display("FAIL midreq data n=%0d got %0d exp %0d", n, out_data, exp_prod(d, p)); end
                vectors++; if (out_first !== (p == 0)) begin miscompares++; $display("FAIL midreq first n=%0d got %b exp %b", n, out_first, p == 0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rr();
        test_back_to_back();
        test_reset_mid();
        test_mid_request();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mul_sel_sched.md
Name: mul_sel_sched

Overview:
Round-robin scheduler and sequencer for the shared 4-phase constant-multiply datapath.
- Datapath produces d*1, d*3, d*7, d*8 over four consecutive cycles from one 8-bit operand.
- Arbitrates N requesters for the datapath, latches the granted operand and steps it through the four phases.
- Emits each product tagged with requester id and phase.
- Sits between operand producers and the downstream result consumer; supports back-to-back operands with no idle cycle.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, operand width; result width OW = DW+3 (localparam).
- IDW, $clog2(N_REQ), requester id width (localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  N_REQ*DW  packed operands; requester i at bits [i*DW +: DW].
- req_ready  out  N_REQ  one-hot accept strobe, combinational from state and req_valid.
- out_valid  out  1  product valid.
- out_first  out  1  high with phase 0 (operand-grant marker).
- out_phase  out  2  0..3 = x1, x3, x7, x8.
- out_id  out  IDW  requester owning current product.
- out_data  out  OW  product.
- busy  out  1  sequencer in RUN.

Behaviour:
- Reset values: all registered outputs 0, state IDLE, phase counter 0, rr pointer 0. req_ready is all-zero while rst=1.
- Reset takes effect at the next clk edge and aborts any in-flight operand. No further phases are emitted, and the operand is not re-queued.
- States:
  - IDLE: arbitrate; on accept go to RUN, phase 0.
  - RUN: phase advances 0->1->2->3 each cycle.
  - At phase 3: arbitrate again. If accepted, go to phase 0 of the new operand; else go to IDLE.
- Arbitration:
  - Occurs only in IDLE or RUN phase 3; req_ready is 0 in all other cycles.
  - Round-robin: search starts at index ptr, wrapping modulo N_REQ. First valid wins.
  - On grant, ptr <= winner+1 (mod N_REQ).
  - Accept = req_valid[i] & req_ready[i]; operand and id are latched on that edge.
- Requester rule: hold valid and data stable until accepted. Dropping valid early is legal; the request is simply not considered.
- Latency: accept at edge T puts phase 0 on outputs after edge T+1. Phases 1..3 follow on consecutive cycles with out_valid continuously high.
- Back-to-back operation: phase 3 of operand A is followed directly by phase 0 of operand B, giving 100% utilisation.
- Products use shift-add only, with no multiplier. All zero-extended to OW; max 255*8 = 2040 fits in 11 bits.
  - x1 = d
  - x3 = (d<<1)+d
  - x7 = (d<<3)-d
  - x8 = d<<3
- out_first = out_valid & (out_phase==0).
- busy = (state==RUN).
- Single requester always valid: it is granted every 4 cycles with no gap.
- No valid requester at phase 3: out_valid drops after the phase-3 cycle.

Optional Feature:
- Macro MULSEL_OUT_REG_EN.
- Defined: one extra register stage on out_valid/out_first/out_phase/out_id/out_data. Accept-to-phase-0 latency becomes 2 cycles. rst also clears this stage.
- Undefined: latency 1 as above.
- Arbitration timing is identical in both cases.

Decomposition:
- Package mul_sel_pkg holds:
  - the phase encoding constants PH_X1..PH_X8 (0..3);
  - the state typedef (IDLE, RUN);
  - the function computing a product from operand and phase.
- One sub-module, rr_arb. Inputs: req vector, enable, ptr. Outputs: one-hot grant and encoded winner.
- Top holds FSM, phase counter, operand/id registers and output stage.

Test Plan:
- Reset then req_valid[0]=1, data=8'hFF: one-cycle ready[0]; next four cycles out_data 255, 765, 1785, 2040; out_first only on the first; out_id 0.
- Requesters 0..3 all valid continuously: grants 0,1,2,3,0 every 4 cycles with no out_valid gap; out_id follows the same order.
- Requester 2 only, data=8'd10: products 10, 30, 70, 80 repeating with no bubble. ready[2] pulses only in phase-3 cycles (plus the first IDLE cycle).
- rst asserted during phase 1 of data=8'd5: next cycle out_valid=0, busy=0, ptr=0; phases 2/3 never appear.
- Request raised during phase 1: req_ready stays 0 until phase 3, then accepted; no products are lost or duplicated.
- With MULSEL_OUT_REG_EN: scenario 1 repeated; phase 0 appears one cycle later and grant timing is unchanged.
